// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 codes and FSM states.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_RESP
   } state_e;

endpackage

// File: rtl/lsu_rmw_if.sv
// Request/response and word-memory bus of the load/store unit.
interface lsu_rmw_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr_en, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads, lane merge for sub-word stores, request legality.
// LSU_MISALIGN_CHECK_EN adds misaligned halfword/word accesses to the error set.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        chk_we_i,
   input  logic [2:0]  chk_funct3_i,
   input  logic [1:0]  chk_off_i,
   output logic        err_o,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

`ifdef LSU_MISALIGN_CHECK_EN
   localparam logic MisalignChk = 1'b1;
`else
   localparam logic MisalignChk = 1'b0;
`endif

   logic        illegal;
   logic        misal;
   logic [7:0]  byte_l;
   logic [15:0] half_l;

   always_comb begin
      if (chk_we_i) illegal = !(chk_funct3_i inside {F3_B, F3_H, F3_W});
      else          illegal = !(chk_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      case (chk_funct3_i)
         F3_H, F3_HU: misal = chk_off_i[0];
         F3_W:        misal = |chk_off_i;
         default:     misal = 1'b0;
      endcase
      err_o = illegal | (MisalignChk & misal);
   end

   // Without the misalign check, sub-size offset bits are simply dropped.
   always_comb begin
      byte_l = rdata_i[{off_i, 3'b000} +: 8];
      half_l = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    load_o = {{24{byte_l[7]}}, byte_l};
         F3_H:    load_o = {{16{half_l[15]}}, half_l};
         F3_W:    load_o = rdata_i;
         F3_BU:   load_o = {24'h0, byte_l};
         F3_HU:   load_o = {16'h0, half_l};
         default: load_o = '0;
      endcase
   end

   always_comb begin
      merge_o = rdata_i;
      case (funct3_i)
         F3_B: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
         F3_H: begin
            if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
            else          merge_o[15:0]  = wdata_i[15:0];
         end
         F3_W:    merge_o = wdata_i;
         default: merge_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit driving a word-wide memory; sub-word stores are read-modify-write.
// LSU_MISALIGN_CHECK_EN (see lsu_align) turns misaligned accesses into errors.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   lsu_rmw_if.slave   bus
);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] mwdata_q, mwdata_d;

   logic              req_err;
   logic [31:0]       load_data;
   logic [31:0]       merge_data;

   lsu_align u_align (
      .chk_we_i     (bus.req_we),
      .chk_funct3_i (bus.req_funct3),
      .chk_off_i    (bus.req_addr[1:0]),
      .err_o        (req_err),
      .funct3_i     (f3_q),
      .off_i        (off_q),
      .rdata_i      (bus.mem_rdata),
      .wdata_i      (wdata_q),
      .load_o       (load_data),
      .merge_o      (merge_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (req_err)                             state_d = ST_RESP;
               else if (bus.req_we && bus.req_funct3 == F3_W) state_d = ST_WRITE;
               else                                     state_d = ST_READ;
            end
         end
         ST_READ:  state_d = ST_WAIT;
         ST_WAIT:  state_d = we_q ? ST_WRITE : ST_RESP;
         ST_WRITE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q == ST_IDLE);
      bus.rsp_valid = (state_q == ST_RESP);
      bus.mem_wr_en = (state_q == ST_WRITE);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
      bus.mem_addr  = maddr_q;
      bus.mem_wdata = mwdata_q;
   end

   // mem_addr/mem_wdata only move for requests that will actually touch memory.
   always_comb begin
      we_d     = we_q;
      f3_d     = f3_q;
      off_d    = off_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               f3_d    = bus.req_funct3;
               off_d   = bus.req_addr[1:0];
               wdata_d = bus.req_wdata;
               rdata_d = '0;
               err_d   = req_err;
               if (!req_err) begin
                  maddr_d = {2'b00, bus.req_addr[ADDR_W-1:2]};
                  if (bus.req_we && bus.req_funct3 == F3_W) mwdata_d = bus.req_wdata;
               end
            end
         end
         ST_WAIT: begin
            if (we_q) mwdata_d = merge_data;
            else      rdata_d  = load_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         f3_q     <= '0;
         off_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         we_q     <= we_d;
         f3_q     <= f3_d;
         off_q    <= off_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw against a small registered-read word memory.
module tb_lsu_rmw;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_rmw_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   lsu_rmw #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [16];
   logic        bd_we = 1'b0;
   logic [3:0]  bd_idx = '0;
   logic [31:0] bd_data = '0;

   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      else if (bus.mem_wr_en) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[3:0]];
   end

   int n_chk = 0;
   int n_fail = 0;
   int rsp_cyc, wr_cnt, wr_cyc;
   logic [31:0] rsp_data, wr_data, wr_addr;
   logic rsp_e;

   task automatic poke(input logic [3:0] idx, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_idx = idx; bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int g = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
      if (g >= 20) begin n_chk++; n_fail++; $display("FAIL ready_timeout: req_ready stuck at %b, expected 1", bus.req_ready); end
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      rsp_cyc = -1; wr_cnt = 0; wr_cyc = -1; rsp_data = '0; rsp_e = 1'b0; wr_data = '0; wr_addr = '0;
      for (int c = 1; c <= 8; c++) begin
         if (bus.mem_wr_en === 1'b1) begin wr_cnt++; wr_cyc = c; wr_data = bus.mem_wdata; wr_addr = bus.mem_addr; end
         if (bus.rsp_valid === 1'b1) begin rsp_cyc = c; rsp_data = bus.rsp_rdata; rsp_e = bus.rsp_err; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", bus.req_ready); end
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
      n_chk++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h expected 0", bus.rsp_rdata); end
      n_chk++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b expected 0", bus.rsp_err); end
      n_chk++; if (bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b expected 0", bus.mem_wr_en); end
      n_chk++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
      n_chk++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
      rst_n = 1'b1;
   endtask

   task automatic test_loads();
      poke(4'd1, 32'h8000_00F0);
      issue(1'b0, 3'b000, 32'h4, 32'h0);
      n_chk++; if (rsp_data !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL lb_data: got %h expected ffff_fff0", rsp_data); end
      n_chk++; if (rsp_cyc !== 3) begin n_fail++; $display("FAIL lb_cycle: got %0d expected 3", rsp_cyc); end
      n_chk++; if (rsp_e !== 1'b0) begin n_fail++; $display("FAIL lb_err: got %b expected 0", rsp_e); end
      n_chk++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL lb_no_write: got %0d writes expected 0", wr_cnt); end
      issue(1'b0, 3'b100, 32'h4, 32'h0);
      n_chk++; if (rsp_data !== 32'h0000_00F0) begin n_fail++; $display("FAIL lbu_data: got %h expected 0000_00f0", rsp_data); end
      issue(1'b0, 3'b001, 32'h6, 32'h0);
      n_chk++; if (rsp_data !== 32'hFFFF_8000) begin n_fail++; $display("FAIL lh_data: got %h expected ffff_8000", rsp_data); end
      issue(1'b0, 3'b101, 32'h6, 32'h0);
      n_chk++; if (rsp_data !== 32'h0000_8000) begin n_fail++; $display("FAIL lhu_data: got %h expected 0000_8000", rsp_data); end
      issue(1'b0, 3'b000, 32'h7, 32'h0);
      n_chk++; if (rsp_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_lane3: got %h expected ffff_ff80", rsp_data); end
   endtask

   task automatic test_sub_store();
      poke(4'd1, 32'h1122_3344);
      issue(1'b1, 3'b000, 32'h6, 32'h0000_00AB);
      n_chk++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL sb_wr_count: got %0d expected 1", wr_cnt); end
      n_chk++; if (wr_data !== 32'h11AB_3344) begin n_fail++; $display("FAIL sb_wdata: got %h expected 11ab_3344", wr_data); end
      n_chk++; if (wr_cyc !== 3) begin n_fail++; $display("FAIL sb_wr_cycle: got %0d expected 3", wr_cyc); end
      n_chk++; if (rsp_cyc !== 4) begin n_fail++; $display("FAIL sb_rsp_cycle: got %0d expected 4", rsp_cyc); end
      n_chk++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL sb_rsp_rdata: got %h expected 0", rsp_data); end
      n_chk++; if (mem[1] !== 32'h11AB_3344) begin n_fail++; $display("FAIL sb_mem: got %h expected 11ab_3344", mem[1]); end
      issue(1'b1, 3'b001, 32'h4, 32'h1234_5566);
      n_chk++; if (wr_data !== 32'h11AB_5566) begin n_fail++; $display("FAIL sh_wdata: got %h expected 11ab_5566", wr_data); end
      n_chk++; if (wr_addr !== 32'h1) begin n_fail++; $display("FAIL sh_wr_addr: got %h expected 1", wr_addr); end
   endtask

   task automatic test_sw();
      issue(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF);
      n_chk++; if (wr_cyc !== 1) begin n_fail++; $display("FAIL sw_wr_cycle: got %0d expected 1", wr_cyc); end
      n_chk++; if (rsp_cyc !== 2) begin n_fail++; $display("FAIL sw_rsp_cycle: got %0d expected 2", rsp_cyc); end
      n_chk++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL sw_wr_count: got %0d expected 1", wr_cnt); end
      n_chk++; if (wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h expected dead_beef", wr_data); end
      n_chk++; if (wr_addr !== 32'h2) begin n_fail++; $display("FAIL sw_wr_addr: got %h expected 2", wr_addr); end
      issue(1'b0, 3'b010, 32'h8, 32'h0);
      n_chk++; if (rsp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h expected dead_beef", rsp_data); end
      n_chk++; if (rsp_cyc !== 3) begin n_fail++; $display("FAIL lw_cycle: got %0d expected 3", rsp_cyc); end
   endtask

   task automatic test_misalign();
      poke(4'd0, 32'h8001_0000);
      issue(1'b0, 3'b001, 32'h3, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
      n_chk++; if (rsp_e !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b expected 1", rsp_e); end
      n_chk++; if (rsp_cyc !== 1) begin n_fail++; $display("FAIL mis_cycle: got %0d expected 1", rsp_cyc); end
      n_chk++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL mis_data: got %h expected 0", rsp_data); end
      n_chk++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL mis_no_write: got %0d expected 0", wr_cnt); end
`else
      n_chk++; if (rsp_e !== 1'b0) begin n_fail++; $display("FAIL mis_err: got %b expected 0", rsp_e); end
      n_chk++; if (rsp_cyc !== 3) begin n_fail++; $display("FAIL mis_cycle: got %0d expected 3", rsp_cyc); end
      n_chk++; if (rsp_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL mis_data: got %h expected ffff_8001", rsp_data); end
`endif
   endtask

   task automatic test_illegal();
      logic [31:0] a0;
      a0 = bus.mem_addr;
      issue(1'b0, 3'b011, 32'h10, 32'h0);
      n_chk++; if (rsp_e !== 1'b1) begin n_fail++; $display("FAIL ill_ld_err: got %b expected 1", rsp_e); end
      n_chk++; if (rsp_cyc !== 1) begin n_fail++; $display("FAIL ill_ld_cycle: got %0d expected 1", rsp_cyc); end
      n_chk++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL ill_ld_data: got %h expected 0", rsp_data); end
      n_chk++; if (bus.mem_addr !== a0) begin n_fail++; $display("FAIL ill_ld_addr_hold: got %h expected %h", bus.mem_addr, a0); end
      issue(1'b1, 3'b100, 32'hC, 32'hFFFF_FFFF);
      n_chk++; if (rsp_e !== 1'b1) begin n_fail++; $display("FAIL ill_st_err: got %b expected 1", rsp_e); end
      n_chk++; if (rsp_cyc !== 1) begin n_fail++; $display("FAIL ill_st_cycle: got %0d expected 1", rsp_cyc); end
      n_chk++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL ill_st_no_write: got %0d expected 0", wr_cnt); end
      n_chk++; if (bus.mem_addr !== a0) begin n_fail++; $display("FAIL ill_st_addr_hold: got %h expected %h", bus.mem_addr, a0); end
   endtask

   task automatic test_reset_mid();
      int g = 0;
      int seen_rsp = 0;
      int seen_wr = 0;
      poke(4'd1, 32'h1122_3344);
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001; bus.req_addr = 32'h4; bus.req_wdata = 32'h0000_5555;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_chk++; if (bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en: got %b expected 0", bus.mem_wr_en); end
      n_chk++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_mem_addr: got %h expected 0", bus.mem_addr); end
      n_chk++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL mid_mem_wdata: got %h expected 0", bus.mem_wdata); end
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b expected 0", bus.rsp_valid); end
      n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", bus.req_ready); end
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid === 1'b1) seen_rsp++;
         if (bus.mem_wr_en === 1'b1) seen_wr++;
      end
      n_chk++; if (mem[1] !== 32'h1122_3344) begin n_fail++; $display("FAIL mid_mem_kept: got %h expected 1122_3344", mem[1]); end
      n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b expected 1", bus.req_ready); end
      n_chk++; if (seen_rsp !== 0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", seen_rsp); end
      n_chk++; if (seen_wr !== 0) begin n_fail++; $display("FAIL mid_no_write: got %0d pulses expected 0", seen_wr); end
      issue(1'b0, 3'b010, 32'h4, 32'h0);
      n_chk++; if (rsp_data !== 32'h1122_3344) begin n_fail++; $display("FAIL mid_reload: got %h expected 1122_3344", rsp_data); end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_sub_store();
      test_sw();
      test_misalign();
      test_illegal();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit between the execute stage and the word-addressed data memory. Takes one RV32I load/store request at a time and drives the memory's word-wide port: word address, write enable, write data, with one-cycle registered read data. Handles byte/halfword selection and sign/zero extension for loads. Implements sub-word stores as read-modify-write, because the memory has no byte enables.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of requests.
- DATA_W, 32, data width; fixed at 32 for RV32I.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock shared with the data memory.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal funct3 or misaligned access, qualified by rsp_valid.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  ADDR_W  word index, equal to req_addr >> 2.
- mem_wdata  out  DATA_W  full word to write.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read cycle.

## Operation
States: IDLE, READ, WAIT, WRITE, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid, capture we, funct3, addr[1:0] offset, wdata and word address.
  - Error request → RESP. SW → WRITE. Anything else → READ.
- **READ**: mem_wr_en=0 and mem_addr=word address; the memory latches the word at the end of this cycle. → WAIT.
- **WAIT**: mem_rdata is valid.
  - Load: select the lane, extend it, and register the result into rsp_rdata. → RESP.
  - SB/SH: register the merged word into mem_wdata. → WRITE.
- **WRITE**: mem_wr_en=1 for exactly one cycle. → RESP.
- **RESP**: rsp_valid=1 for one cycle. → IDLE. There is no response backpressure.
- Load funct3 codes:
  - 000 LB: byte, sign-extended.
  - 001 LH: halfword, sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: halfword, zero-extended.
  - All other load codes are illegal.
- Store funct3 codes: 000 SB, 001 SH, 010 SW; all other store codes are illegal.
- Lane selection:
  - Byte lane = addr[1:0].
  - Halfword lane = addr[1]; bits [31:16] when addr[1]=1.
- Merge: only the addressed lane is replaced by the low bits of wdata; all other bytes keep their mem_rdata value.
- Any illegal funct3 responds with rsp_err=1 and no memory access, with or without the configuration macro.

## Timing
- Reset values:
  - State IDLE, req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_wr_en=0, mem_addr=0, mem_wdata=0.
- mem_wr_en is decoded from the state register, so reset drops it immediately.
- Latency, counted from the accepting edge (cycle 0 = IDLE):
  - Loads: rsp_valid in cycle 3.
  - SW: rsp_valid in cycle 2.
  - SB/SH: rsp_valid in cycle 4.
  - Errors: rsp_valid in cycle 1.
- A new request can be accepted in the cycle after RESP. Throughput is one request per 2–5 cycles.
- mem_addr and mem_wdata hold their last value outside READ and WRITE.
- Reset mid-operation abandons the access:
  - An RMW interrupted before its WRITE edge leaves memory unchanged.
  - No rsp_valid is produced for the abandoned request.
- req_* inputs are ignored outside IDLE.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - LH, LHU or SH with addr[0]=1, and LW or SW with addr[1:0]≠0, respond with rsp_err=1 and rsp_rdata=0.
  - No memory cycle is issued.
- Macro undefined:
  - Offset bits below the access size are ignored: halfword uses addr[1] only, word ignores addr[1:0].
  - The access proceeds normally with rsp_err=0.

## Structure
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding constants.
- Combinational sub-module lsu_align contains:
  - Load-lane extraction and extension.
  - Store-lane merge.
  - Misalignment/illegal detect.
- The top level holds the FSM and the registers.

## Test plan
- Memory word 1 = 0x8000_00F0:
  - LB at 0x4 → rsp_rdata 0xFFFF_FFF0, rsp_valid in cycle 3.
  - LBU at 0x4 → 0x0000_00F0.
  - LH at 0x6 → 0xFFFF_8000.
- Memory word 1 = 0x1122_3344, SB wdata 0x0000_00AB at 0x6 → one mem_wr_en pulse with mem_wdata 0x11AB_3344; rsp_valid in cycle 4.
- SW 0xDEAD_BEEF at 0x8 → no READ state, mem_wr_en in cycle 1, rsp in cycle 2. A following LW at 0x8 returns 0xDEAD_BEEF.
- LH at 0x3, word 0 = 0x8001_0000:
  - With macro: rsp_err=1 in cycle 1 and mem_wr_en never asserts.
  - Without macro: rsp_rdata 0xFFFF_8001, rsp_err=0.
- Load with funct3 011, and store with funct3 100 → rsp_err=1 in cycle 1, no memory access.
- SH 0x5555 at 0x4 over word 0x1122_3344, rst_n asserted during WAIT → all outputs at reset values immediately; word stays 0x1122_3344; req_ready=1 after release.
